// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - register-file write-port scheduler for fast results and in-order load returns
// Optional statistics counters (stat_fast/stat_load/stat_conflict) are built when WB_STAT_EN is defined.

`ifndef WSEL_ALU
`define WSEL_ALU  2'b00
`endif
`ifndef WSEL_RAM
`define WSEL_RAM  2'b01
`endif
`ifndef WSEL_PC
`define WSEL_PC   2'b10
`endif
`ifndef WSEL_SEXT
`define WSEL_SEXT 2'b11
`endif

module rf_wb_scheduler #(
    parameter int LD_DEPTH = 4,
    parameter int PTR_W    = 2
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_rf_we,
    input  logic [1:0]  ex_wsel,
    input  logic [4:0]  ex_wreg,
    input  logic [31:0] ex_alu_c,
    input  logic [31:0] ex_pc4,
    input  logic [31:0] ex_sext,
    output logic        ld_req,
    input  logic        ld_rvalid,
    input  logic [31:0] ld_rdata,
    input  logic        flush,
    output logic        drained,
    output logic        rf_we,
    output logic [4:0]  rf_wr,
    output logic [31:0] rf_wD,
    output logic [31:0] rf_busy,
    output logic        err_spurious
`ifdef WB_STAT_EN
    ,
    output logic [31:0] stat_fast,
    output logic [31:0] stat_load,
    output logic [31:0] stat_conflict
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(LD_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    state_t state, state_next;

    logic             fifo_we  [LD_DEPTH];
    logic [4:0]       fifo_reg [LD_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, scan_idx;
    logic [PTR_W:0]   count, count_next;

    logic        is_load, in_run, ld_pop;
    logic        fast_ok, load_ok, accept_fast, accept_load;
    logic        wr_flag, head_we, head_shared;
    logic [4:0]  head_reg;
    logic [31:0] fast_data, busy_next;

    assign is_load = (ex_wsel == `WSEL_RAM);
    assign in_run  = (state == RUN);
    assign ld_pop  = ld_rvalid && (count != '0);
    assign wr_flag = ex_rf_we && (ex_wreg != 5'd0);

    // A load return owns the write port, so any ld_rvalid blocks fast ops.
    assign fast_ok = in_run && !ld_rvalid && !cpu_rst;
    assign load_ok = in_run && ((count < DEPTH_C) || ld_pop) && !cpu_rst;

    assign ex_ready    = ex_valid && (is_load ? load_ok : fast_ok);
    assign accept_fast = ex_valid && !is_load && fast_ok;
    assign accept_load = ex_valid && is_load && load_ok;
    assign ld_req      = accept_load;

    assign head_we  = fifo_we[rd_ptr];
    assign head_reg = fifo_reg[rd_ptr];

    always_comb begin
        fast_data = ex_alu_c;
        case (ex_wsel)
            `WSEL_PC:   fast_data = ex_pc4;
            `WSEL_SEXT: fast_data = ex_sext;
            default:    fast_data = ex_alu_c;
        endcase
    end

    // Does any younger pending load still target the head's register?
    always_comb begin
        head_shared = 1'b0;
        scan_idx    = rd_ptr;
        for (int i = 1; i < LD_DEPTH; i++) begin
            scan_idx = rd_ptr + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && fifo_we[scan_idx] &&
                (fifo_reg[scan_idx] == head_reg))
                head_shared = 1'b1;
        end
    end

    always_comb begin
        count_next = count;
        case ({accept_load, ld_pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_comb begin
        busy_next = rf_busy;
        if (ld_pop && head_we && !head_shared)
            busy_next[head_reg] = 1'b0;
        if (accept_load && wr_flag)
            busy_next[ex_wreg] = 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (flush) state_next = DRAIN;
            DRAIN:   if (drained && !flush) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state   <= RUN;
            drained <= 1'b0;
        end else begin
            state   <= state_next;
            drained <= (state_next == DRAIN) && (count_next == '0);
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (accept_load) begin
            fifo_we[wr_ptr]  <= wr_flag;
            fifo_reg[wr_ptr] <= ex_wreg;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rf_busy      <= '0;
            rf_we        <= 1'b0;
            rf_wr        <= 5'd0;
            rf_wD        <= 32'd0;
            err_spurious <= 1'b0;
        end else begin
            count   <= count_next;
            rf_busy <= busy_next;
            if (accept_load)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (ld_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (ld_rvalid && (count == '0))
                err_spurious <= 1'b1;

            if (ld_pop) begin
                rf_we <= head_we;
                rf_wr <= head_reg;
                rf_wD <= ld_rdata;
            end else if (accept_fast) begin
                rf_we <= wr_flag;
                rf_wr <= ex_wreg;
                rf_wD <= fast_data;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

`ifdef WB_STAT_EN
    logic fast_blocked;
    assign fast_blocked = ex_valid && !is_load && in_run && ld_pop;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            stat_fast     <= 32'd0;
            stat_load     <= 32'd0;
            stat_conflict <= 32'd0;
        end else begin
            if (accept_fast && wr_flag && (stat_fast != '1))
                stat_fast <= stat_fast + 32'd1;
            if (ld_pop && head_we && (stat_load != '1))
                stat_load <= stat_load + 32'd1;
            if (fast_blocked && (stat_conflict != '1))
                stat_conflict <= stat_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - directed bench with a queue-based reference model for rf_wb_scheduler

module tb_rf_wb_scheduler;

    localparam int         DEPTH  = 4;
    localparam logic [1:0] W_ALU  = 2'b00;
    localparam logic [1:0] W_RAM  = 2'b01;
    localparam logic [1:0] W_PC   = 2'b10;
    localparam logic [1:0] W_SEXT = 2'b11;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        ex_valid = 1'b0, ex_rf_we = 1'b0;
    logic [1:0]  ex_wsel = 2'b00;
    logic [4:0]  ex_wreg = 5'd0;
    logic [31:0] ex_alu_c = 32'd0, ex_pc4 = 32'd0, ex_sext = 32'd0;
    logic        ld_rvalid = 1'b0;
    logic [31:0] ld_rdata = 32'd0;
    logic        flush = 1'b0;
    logic        ex_ready, ld_req, drained, rf_we, err_spurious;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wD, rf_busy;

    int tests = 0;
    int fails = 0;

    rf_wb_scheduler #(.LD_DEPTH(4), .PTR_W(2)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rf_we(ex_rf_we),
        .ex_wsel(ex_wsel), .ex_wreg(ex_wreg), .ex_alu_c(ex_alu_c),
        .ex_pc4(ex_pc4), .ex_sext(ex_sext), .ld_req(ld_req),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .flush(flush),
        .drained(drained), .rf_we(rf_we), .rf_wr(rf_wr), .rf_wD(rf_wD),
        .rf_busy(rf_busy), .err_spurious(err_spurious)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Reference model: pending loads as a queue of {write flag, reg}
    logic [5:0]  pend[$];
    bit          m_drain = 1'b0;
    logic        m_we = 1'b0, m_err = 1'b0;
    logic [4:0]  m_wr = 5'd0;
    logic [31:0] m_wd = 32'd0;
    logic        m_acc, m_isld, m_dr;
    logic [5:0]  m_head;

    function automatic logic [31:0] m_busy();
        logic [31:0] b = 32'd0;
        foreach (pend[i])
            if (pend[i][5]) b[pend[i][4:0]] = 1'b1;
        return b;
    endfunction

    function automatic logic m_ready();
        if (cpu_rst || !ex_valid || m_drain) return 1'b0;
        if (ex_wsel == W_RAM)
            return (pend.size() < DEPTH) || (ld_rvalid && pend.size() > 0);
        return !ld_rvalid;
    endfunction

    function automatic logic m_drained();
        return m_drain && (pend.size() == 0);
    endfunction

    function automatic logic [31:0] m_sel();
        if (ex_wsel == W_PC)   return ex_pc4;
        if (ex_wsel == W_SEXT) return ex_sext;
        return ex_alu_c;
    endfunction

    always @(posedge cpu_clk) begin
        if (cpu_rst) begin
            pend.delete();
            m_drain = 1'b0;
            m_we = 1'b0; m_wr = 5'd0; m_wd = 32'd0; m_err = 1'b0;
        end else begin
            m_acc  = m_ready();
            m_isld = (ex_wsel == W_RAM);
            m_dr   = m_drained();
            if (ld_rvalid && pend.size() > 0) begin
                m_head = pend.pop_front();
                m_we = m_head[5]; m_wr = m_head[4:0]; m_wd = ld_rdata;
            end else begin
                if (ld_rvalid) m_err = 1'b1;
                if (m_acc && !m_isld) begin
                    m_we = ex_rf_we && (ex_wreg != 5'd0);
                    m_wr = ex_wreg;
                    m_wd = m_sel();
                end else begin
                    m_we = 1'b0;
                end
            end
            if (m_acc && m_isld)
                pend.push_back({ex_rf_we && (ex_wreg != 5'd0), ex_wreg});
            if (!m_drain) m_drain = flush;
            else if (m_dr && !flush) m_drain = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge cpu_clk) begin
        #4;
        check("ex_ready", ex_ready, m_ready());
        check("ld_req", ld_req, m_ready() && (ex_wsel == W_RAM));
        check("drained", drained, m_drained());
        check("rf_we", rf_we, m_we);
        check("rf_wr", rf_wr, m_wr);
        check("rf_wD", rf_wD, m_wd);
        check("rf_busy", rf_busy, m_busy());
        check("err_spurious", err_spurious, m_err);
    end

    task automatic tick();
        @(negedge cpu_clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_rf_we = 0; ex_wsel = W_ALU; ex_wreg = 0;
        ex_alu_c = 0; ex_pc4 = 0; ex_sext = 0;
        ld_rvalid = 0; ld_rdata = 0; flush = 0;
    endtask

    task automatic offer(input logic [1:0] sel, input logic [4:0] rd, input logic we);
        ex_valid = 1; ex_wsel = sel; ex_wreg = rd; ex_rf_we = we;
    endtask

    task automatic ret(input logic [31:0] d);
        ld_rvalid = 1; ld_rdata = d;
    endtask

    initial begin
        idle();
        repeat (3) tick();
        cpu_rst = 0;
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_wD", rf_wD, 0);
        check("rst_busy", rf_busy, 0);
        check("rst_err", err_spurious, 0);

        // fast ALU write, then SEXT write to r0
        offer(W_ALU, 5'd5, 1'b1); ex_alu_c = 32'h1234;
        #1 check("t1_ready", ex_ready, 1);
        tick(); idle();
        check("t1_we", rf_we, 1);
        check("t1_wr", rf_wr, 5);
        check("t1_wD", rf_wD, 32'h1234);
        offer(W_SEXT, 5'd0, 1'b1); ex_sext = 32'h55;
        tick(); idle();
        check("t1_r0_we", rf_we, 0);

        // load r7, return three cycles later
        offer(W_RAM, 5'd7, 1'b1);
        #1 check("t2_ld_req", ld_req, 1);
        tick(); idle();
        check("t2_busy", rf_busy, 32'h80);
        tick(); tick();
        ret(32'hDEADBEEF);
        tick(); idle();
        check("t2_we", rf_we, 1);
        check("t2_wr", rf_wr, 7);
        check("t2_wD", rf_wD, 32'hDEADBEEF);
        check("t2_busy_clr", rf_busy, 0);

        // port conflict: load return beats a PC+4 write
        offer(W_RAM, 5'd9, 1'b1);
        tick(); idle();
        ret(32'hA5A5); offer(W_PC, 5'd1, 1'b1); ex_pc4 = 32'h80;
        #1 check("t3_blocked", ex_ready, 0);
        tick(); ld_rvalid = 0; ld_rdata = 0;
        check("t3_ld_wr", rf_wr, 9);
        check("t3_ld_wD", rf_wD, 32'hA5A5);
        #1 check("t3_ready", ex_ready, 1);
        tick(); idle();
        check("t3_fast_wr", rf_wr, 1);
        check("t3_fast_wD", rf_wD, 32'h80);

        // fill the FIFO, then push alongside a pop
        for (int i = 0; i < 4; i++) begin
            offer(W_RAM, 5'(10 + i), 1'b1);
            tick();
        end
        offer(W_RAM, 5'd14, 1'b1);
        #1 check("t4_full", ex_ready, 0);
        tick();
        ret(32'h1010);
        #1 check("t4_push_pop", ex_ready, 1);
        check("t4_ld_req", ld_req, 1);
        tick(); ld_rvalid = 0; ld_rdata = 0;
        check("t4_wr", rf_wr, 10);
        check("t4_busy", rf_busy, 32'h7800);
        offer(W_RAM, 5'd15, 1'b1);
        #1 check("t4_still_full", ex_ready, 0);
        for (int i = 0; i < 4; i++) begin
            ex_valid = 0;
            ret(32'h2000 + i);
            tick();
            check("t4_ret_wr", rf_wr, 11 + i);
        end
        idle();
        check("t4_busy_empty", rf_busy, 0);

        // duplicate destinations and a load to r0
        offer(W_RAM, 5'd3, 1'b1); tick();
        offer(W_RAM, 5'd3, 1'b1); tick();
        offer(W_RAM, 5'd0, 1'b1); tick(); idle();
        check("t5_busy", rf_busy, 32'h8);
        ret(32'h33); tick();
        check("t5_busy_held", rf_busy, 32'h8);
        ret(32'h34); tick();
        check("t5_busy_clr", rf_busy, 0);
        check("t5_we", rf_we, 1);
        ret(32'h35); tick(); idle();
        check("t5_r0_we", rf_we, 0);

        // flush with two loads pending
        offer(W_RAM, 5'd4, 1'b1); tick();
        offer(W_RAM, 5'd6, 1'b1); tick(); idle();
        flush = 1; tick(); flush = 0;
        check("t6_not_drained", drained, 0);
        offer(W_ALU, 5'd2, 1'b1); ex_alu_c = 32'h22;
        #1 check("t6_blocked", ex_ready, 0);
        ret(32'h44); flush = 1; tick(); flush = 0;
        check("t6_not_drained2", drained, 0);
        ret(32'h66); tick(); ld_rvalid = 0; ld_rdata = 0;
        check("t6_drained", drained, 1);
        check("t6_drain_block", ex_ready, 0);
        tick();
        check("t6_run", drained, 0);
        check("t6_ready", ex_ready, 1);
        ex_valid = 0; ret(32'h77); tick(); idle();
        check("t6_spurious", err_spurious, 1);
        check("t6_spur_we", rf_we, 0);

        // reset with a load pending
        cpu_rst = 1; tick(); cpu_rst = 0;
        offer(W_RAM, 5'd8, 1'b1); tick(); idle();
        check("t7_busy", rf_busy, 32'h100);
        cpu_rst = 1; tick(); cpu_rst = 0;
        check("t7_busy_rst", rf_busy, 0);
        check("t7_err_rst", err_spurious, 0);
        ret(32'h88); tick(); idle();
        check("t7_spurious", err_spurious, 1);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
Schedules the single register-file write port between two sources.
- Fast results: ALU, PC+4 and SEXT, ready in the issue cycle.
- Slow load returns: DRAM data arriving a variable number of cycles later.
- Tracks outstanding load destinations in an in-order FIFO and exposes a busy mask for hazard stalls.
- Sits between the execute stage and the register file; its write data comes from the write-back select mux.

Parameters:
- LD_DEPTH, 4: maximum outstanding loads; power of 2, range 2..16.
- PTR_W, 2: pointer width, equal to log2(LD_DEPTH).

Ports:
- cpu_clk  in  1  clock; all state updates on the rising edge.
- cpu_rst  in  1  synchronous reset, active-high.
- ex_valid  in  1  execute stage offers an instruction.
- ex_ready  out  1  scheduler accepts the instruction this cycle.
- ex_rf_we  in  1  instruction writes rd.
- ex_wsel  in  2  write-back source; encodings are `WSEL_ALU/`WSEL_RAM/`WSEL_PC/`WSEL_SEXT from defines.vh.
- ex_wreg  in  5  destination register.
- ex_alu_c  in  32  ALU result.
- ex_pc4  in  32  PC+4.
- ex_sext  in  32  SEXT result.
- ld_req  out  1  one-cycle pulse: a load was accepted.
- ld_rvalid  in  1  load data returning; returns arrive in order.
- ld_rdata  in  32  load data.
- flush  in  1  drain request, sampled for one cycle.
- drained  out  1  high while in DRAIN with no loads pending.
- rf_we  out  1  register-file write enable (registered).
- rf_wr  out  5  register-file write address (registered).
- rf_wD  out  32  register-file write data (registered).
- rf_busy  out  32  bit i set while a load to register i is pending.
- err_spurious  out  1  sticky flag: ld_rvalid arrived with the FIFO empty.

Behaviour:
- Reset: ex_ready=0, ld_req=0, drained=0, rf_we=0, rf_wr=0, rf_wD=0, rf_busy=0, err_spurious=0. Pointers and count are 0; state is RUN.
- Fast op (ex_wsel != `WSEL_RAM) is accepted when all hold: ex_valid, state RUN, ld_rvalid=0.
  - On the next edge: rf_we = ex_rf_we && ex_wreg != 0, rf_wr = ex_wreg, rf_wD = the selected source. Latency 1 cycle.
- Load op (ex_wsel == `WSEL_RAM) is accepted when ex_valid, state RUN and count < LD_DEPTH. On acceptance:
  - push {ex_rf_we && ex_wreg != 0, ex_wreg} into the FIFO;
  - ld_req=1 for that cycle (combinational);
  - set the rf_busy bit next edge when the write flag is set.
- ex_ready is combinational and equals the acceptance condition for the offered op type.
- Load return (ld_rvalid with count > 0):
  - pop the head;
  - next edge: rf_we = head write flag, rf_wr = head reg, rf_wD = ld_rdata;
  - clear the rf_busy bit only if no other FIFO entry targets the same register.
- Port conflict: a load return always wins the write port. In that cycle a fast op sees ex_ready=0 and must hold its inputs.
- Simultaneous load push and pop in one cycle: count is unchanged; a push is allowed even when count == LD_DEPTH only if a pop happens in the same cycle.
- Pointers wrap modulo LD_DEPTH; count is PTR_W+1 bits wide.
- ld_rvalid with count == 0: ignored, no write, err_spurious=1 until reset.
- rf_we deasserts the cycle after the write unless a new write occurs.
- FSM, RUN -> DRAIN on flush.
  - DRAIN: ex_ready=0; load returns still retire.
  - drained=1 while in DRAIN with count == 0.
  - DRAIN -> RUN the cycle after drained=1 when flush=0.
  - flush while already in DRAIN: stay in DRAIN.
- Reset mid-operation clears the FIFO and busy mask. Subsequent returns count as spurious.

Optional Feature:
- Macro WB_STAT_EN.
- When defined, adds three 32-bit saturating counters, cleared by reset and readable on outputs stat_fast, stat_load, stat_conflict:
  - stat_fast: retired fast writes;
  - stat_load: retired load writes;
  - stat_conflict: cycles with a fast op blocked by a load return.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then fast op: ex_wsel=`WSEL_ALU, ex_wreg=5, ex_alu_c=0x1234 -> next cycle rf_we=1, rf_wr=5, rf_wD=0x1234.
- Load then return: accept a load to r7 -> ld_req pulse, rf_busy[7]=1. ld_rvalid with 0xDEADBEEF three cycles later -> rf_we=1, rf_wr=7, rf_wD=0xDEADBEEF, rf_busy[7]=0.
- Conflict: `WSEL_PC fast op to r1 (pc4=0x80) in the same cycle as a load return -> ex_ready=0, load written first, r1=0x80 written the following cycle.
- Full FIFO, LD_DEPTH=4: issue 4 loads -> 5th load gets ex_ready=0. The same cycle as a return -> the 5th is accepted, count stays 4.
- Duplicate destinations: two loads to r3, first returns -> rf_busy[3] stays 1; second returns -> rf_busy[3]=0. A load to r0 produces no rf_we.
- Flush with 2 loads pending -> ex_ready=0, drained=0 until both return, then drained=1, then RUN. ld_rvalid after that -> err_spurious=1.
